// File: rtl/spi_controller.sv
// Mode-0 SPI master that emits 16-bit {write, addr[6:0], data[7:0]} frames, MSB first,
// and returns the last 8 CIPO bits sampled on rising SCLK edges.
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI,
    input  logic       CIPO
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [4:0]    r_bits;
    logic [14:0]   r_tx;
    logic [7:0]    r_rx;
    logic          r_ncs;
    logic          r_sclk;
    logic          r_copi;
    logic          r_rsp_valid;
    logic [7:0]    r_rsp_rdata;

    logic w_accept;
    logic w_div_done;
    logic w_gap_done;
    logic w_last_bit;
    logic w_rise;
    logic w_fall;
    logic w_cs_rise;
    logic w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // SHIFT runs 32 half-periods; the 32nd (SCLK low after the last fall) ends in HOLD
    // rather than another rising edge.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_cs_rise   = 1'b0;
        w_done      = 1'b0;
        w_div_done  = (r_cnt == DIV_LAST);
        w_gap_done  = (r_cnt == GAP_LAST);
        w_last_bit  = (r_bits == 5'd16);
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_div_done) begin
                    w_rise      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_div_done) begin
                    if (r_sclk)          w_fall      = 1'b1;
                    else if (w_last_bit) w_state_nxt = S_HOLD;
                    else                 w_rise      = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_div_done) begin
                    w_cs_rise   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE || w_state_nxt != r_state || w_rise || w_fall) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // tx holds only bits 14:0; bit 15 goes straight to COPI on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ncs  <= 1'b1;
            r_sclk <= 1'b0;
            r_copi <= 1'b0;
            r_tx   <= '0;
            r_bits <= '0;
        end else begin
            if (w_accept) begin
                r_ncs  <= 1'b0;
                r_copi <= req_write;
                r_tx   <= {req_addr, req_wdata};
                r_bits <= '0;
            end
            if (w_rise) begin
                r_sclk <= 1'b1;
                r_bits <= r_bits + 5'd1;
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                if (!w_last_bit) begin
                    r_copi <= r_tx[14];
                    r_tx   <= {r_tx[13:0], 1'b0};
                end
            end
            if (w_cs_rise) begin
                r_ncs  <= 1'b1;
                r_copi <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_rise) r_rx <= {r_rx[6:0], CIPO};
            r_rsp_valid <= w_done;
            if (w_done) r_rsp_rdata <= r_rx;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign nCS       = r_ncs;
    assign SCLK      = r_sclk;
    assign COPI      = r_copi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/spi_controller.md
# spi_controller

Mode-0 SPI controller that originates the 16-bit register-write frames consumed by the on-chip SPI register peripheral: one write bit, a 7-bit address and 8 data bits, MSB first. It accepts one request at a time over a valid/ready handshake and generates nCS, SCLK and COPI from the system clock. It samples CIPO on every rising SCLK edge and returns the last 8 sampled bits as read data. It is used by the test harness and by on-die configuration logic to program the output-enable, PWM-enable and duty-cycle registers.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period. Must be ≥4 so the peripheral's 2-flop synchronizer sees every edge.
- CS_GAP, 4: minimum clk cycles nCS stays high between frames. Must be ≥3.
- clk  in  1  system clock; all outputs are registered on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_write  in  1  frame bit 15 (1 = write).
- req_addr  in  7  frame bits 14:8.
- req_wdata  in  8  frame bits 7:0.
- rsp_valid  out  1  one-cycle pulse when a frame completes.
- rsp_rdata  out  8  last 8 CIPO samples (frame bits 7:0); held until the next rsp_valid.
- busy  out  1  high in every state except IDLE.
- nCS  out  1  chip select, active-low.
- SCLK  out  1  serial clock; idles low.
- COPI  out  1  serial data out.
- CIPO  in  1  serial data in, sampled directly with no synchronizer.

## Operation
- Reset values: nCS=1, SCLK=0, COPI=0, rsp_valid=0, rsp_rdata=0, busy=0. req_ready=1 (state IDLE).
- Frame register tx[15:0] = {req_write, req_addr, req_wdata}, latched on acceptance. Shift register rx[15:0] captures CIPO samples.
- States and transitions:
  - IDLE: nCS=1, SCLK=0. On acceptance, latch tx and go to SETUP.
  - SETUP: nCS=0, COPI=tx[15]. After CLK_DIV cycles, go to SHIFT.
  - SHIFT: SCLK toggles every CLK_DIV cycles, giving 32 half-periods.
    - At each rising SCLK edge: rx <= {rx[14:0], CIPO}.
    - At each falling SCLK edge except the last: COPI takes the next tx bit.
    - A 5-bit bit counter reaches 16 on the 16th rising edge. After the following falling edge, go to HOLD.
  - HOLD: nCS=0, SCLK=0. After CLK_DIV cycles, raise nCS and go to GAP.
  - GAP: nCS=1. After CS_GAP cycles, pulse rsp_valid, load rsp_rdata <= rx[7:0], and go to IDLE.
- Read frames (req_write=0) still drive req_wdata on COPI.
- req_valid while busy is ignored. Request inputs are sampled only in the acceptance cycle; later changes have no effect.
- Reset mid-frame forces all reset values immediately and abandons the frame; no rsp_valid is issued.
- COPI returns to 0 in IDLE.

## Timing
- T = first cycle nCS is low, i.e. the cycle after acceptance.
- Rising SCLK edge k (k=1..16) occurs at T + (2k−1)·CLK_DIV. Falling edge k occurs at T + 2k·CLK_DIV.
- COPI is stable for CLK_DIV cycles before, and CLK_DIV cycles after, every rising edge.
- nCS rises at T + 34·CLK_DIV.
- rsp_valid and req_ready both rise at T + 34·CLK_DIV + CS_GAP; they are asserted in the same cycle.
- A new request may be accepted in that same cycle. Back-to-back frame period = 34·CLK_DIV + CS_GAP + 1 cycles, which is 141 cycles at the defaults.
- The peripheral sees nCS high for at least CS_GAP ≥ 3 cycles between frames.

## Test plan
- Write frame: req_write=1, addr=0x05, wdata=0xA5, defaults. Required response:
  - COPI bits sampled on SCLK rising edges = 0x85A5, MSB first.
  - Exactly 16 rising edges.
  - nCS low for 136 cycles; rsp_valid at T+140.
- Loopback: CIPO driven by a model that presents 0x3C in frame bits 7:0 on a read frame, addr=0x02. Required response: rsp_rdata=0x3C on the rsp_valid pulse and held afterwards.
- Back-to-back: req_valid held high with two requests (0x81_FF then 0x83_0F). Required response:
  - Second acceptance on the same cycle as the first rsp_valid.
  - nCS high exactly CS_GAP=4 cycles between frames.
  - An SPI peripheral model decodes both writes.
- Busy ignore: pulse req_valid with addr=0x04 mid-SHIFT. Required response: req_ready=0, no second frame, no change to the COPI stream.
- Reset mid-frame: assert rst_n=0 after the 7th rising edge. Required response:
  - nCS=1, SCLK=0, COPI=0 immediately.
  - No rsp_valid.
  - After release, a fresh write of 0x01_55 completes correctly.
- Parameter sweep: CLK_DIV=8, CS_GAP=3. Required response: SCLK half-period = 8 cycles, nCS low for 272 cycles, rsp_valid at T+275.
